// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath: operand width and the
// one-hot entry-state encodings consumed by both entry and Calculate stages.
package calc_pkg;

   localparam int OPERAND_W = 8;

   typedef enum logic [2:0] {
      ST_ENTER_A = 3'b001,
      ST_ENTER_B = 3'b010,
      ST_SHOW    = 3'b100
   } entry_state_e;

endpackage

// File: rtl/button_debounce.sv
// Pushbutton conditioner: 2-FF synchronizer, counting debouncer and a
// single-cycle pulse on each accepted press (rising debounced level).
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic pulse
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_p0;
   logic             sync_p1;
   logic             level;
   logic             level_d;
   logic [CNT_W-1:0] cnt;

   // level flips once the synced input has disagreed for DEBOUNCE_CYCLES samples
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         level   <= 1'b0;
         level_d <= 1'b0;
         cnt     <= '0;
      end else begin
         sync_p0 <= btn;
         sync_p1 <= sync_p0;
         level_d <= level;
         if (sync_p1 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level <= ~level;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   assign pulse = level & ~level_d;

endmodule

// File: rtl/operand_entry.sv
// Operand entry sequencer: captures two switch operands on advance presses
// and exposes them with the one-hot entry state to the Calculate stage.
module operand_entry
   import calc_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 btnr,
   input  logic                 btnl,
   input  logic [OPERAND_W-1:0] sw,
   output logic [OPERAND_W-1:0] num1,
   output logic [OPERAND_W-1:0] num2,
   output logic [2:0]           state,
   output logic                 result_valid
);

   logic         adv_pulse;
   logic         clr_pulse;
   entry_state_e st;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_adv (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (btnr),
      .pulse (adv_pulse)
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (btnl),
      .pulse (clr_pulse)
   );

   // clear has priority over advance when both pulses land together
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st           <= ST_ENTER_A;
         num1         <= '0;
         num2         <= '0;
         result_valid <= 1'b0;
      end else if (clr_pulse) begin
         st           <= ST_ENTER_A;
         num1         <= '0;
         num2         <= '0;
         result_valid <= 1'b0;
      end else begin
         case (st)
            ST_ENTER_A: begin
               if (adv_pulse) begin
                  num1 <= sw;
                  st   <= ST_ENTER_B;
               end
            end
            ST_ENTER_B: begin
               if (adv_pulse) begin
                  num2         <= sw;
                  st           <= ST_SHOW;
                  result_valid <= 1'b1;
               end
            end
            ST_SHOW: begin
               if (adv_pulse) begin
                  st           <= ST_ENTER_A;
                  result_valid <= 1'b0;
               end
            end
            default: begin
               st           <= ST_ENTER_A;
               result_valid <= 1'b0;
            end
         endcase
      end
   end

   assign state = st;

endmodule
